max_search_ctrl: RTL and testbench

Sequencing controller for the 2D max-search datapath (counter, data fetch, register file, 3x3 pattern comparator).
- Streams a COL×ROW 8-bit image into the register file write port.
- Enables the scan for exactly the number of interior window positions, then collects the per-window results the datapath emits.
- Tracks the running global maximum and its position.
- Reports the final maximum through a Done/Ack handshake, so the datapath can run as a start-to-finish job under a host or testbench.

---
 rtl/max_search_ctrl_pkg.sv | 33 +++
 rtl/max_search_ctrl_if.sv | 44 ++++
 rtl/max_search_ctrl_max_tracker.sv | 44 ++++
 rtl/max_search_ctrl.sv | 118 +++++++++++
 tb/tb_max_search_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/max_search_ctrl_pkg.sv
// Shared types and constants for the max-search controller.
// State encoding, data/address widths and image-size helpers.
package max_search_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int X_W    = 7;
  localparam int Y_W    = 6;
  localparam int CNT_W  = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } max_search_ctrl_state;

  function automatic logic [CNT_W-1:0] npix(
    input int col,
    input int row
  );
    return CNT_W'(col * row);
  endfunction

  function automatic logic [CNT_W-1:0] nwin(
    input int col,
    input int row
  );
    return CNT_W'((col - 2) * (row - 2));
  endfunction

endpackage

// File: rtl/max_search_ctrl_if.sv
// Host/datapath bundle of the max-search controller.
// slave: controller side; master: host + datapath side.
interface max_search_ctrl_if;
  import max_search_ctrl_pkg::*;

  logic              Start;
  logic [1:0]        Pattern;
  logic              PixValid;
  logic [DATA_W-1:0] PixData;
  logic              PixReady;
  logic              WE;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] D;
  logic              ScanEn;
  logic [1:0]        PatternOut;
  logic              WinValid;
  logic [DATA_W-1:0] WinValue;
  logic [X_W-1:0]    WinX;
  logic [Y_W-1:0]    WinY;
  logic              Busy;
  logic              Done;
  logic              Ack;
  logic [DATA_W-1:0] BestValue;
  logic [X_W-1:0]    BestX;
  logic [Y_W-1:0]    BestY;
  logic              BestValid;

  modport slave (
    input  Start, Pattern, PixValid, PixData,
    input  WinValid, WinValue, WinX, WinY, Ack,
    output PixReady, WE, WA, D, ScanEn,
    output PatternOut, Busy, Done,
    output BestValue, BestX, BestY, BestValid
  );

  modport master (
    output Start, Pattern, PixValid, PixData,
    output WinValid, WinValue, WinX, WinY, Ack,
    input  PixReady, WE, WA, D, ScanEn,
    input  PatternOut, Busy, Done,
    input  BestValue, BestX, BestY, BestValid
  );

endinterface

// File: rtl/max_search_ctrl_max_tracker.sv
// Running global maximum with position; ties keep the first.
// clr/upd/fin in, best_* and best_valid (job complete) out.
module max_tracker
  import max_search_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic              fin,
  input  logic [DATA_W-1:0] value,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [DATA_W-1:0] best_value,
  output logic [X_W-1:0]    best_x,
  output logic [Y_W-1:0]    best_y,
  output logic              best_valid
);

  // hit: at least one result taken in this job
  logic hit;
  logic take;

  assign take = upd && (!hit || value > best_value);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hit        <= 1'b0;
      best_value <= '0;
      best_x     <= '0;
      best_y     <= '0;
      best_valid <= 1'b0;
    end else begin
      if (take) begin
        hit        <= 1'b1;
        best_value <= value;
        best_x     <= x;
        best_y     <= y;
      end
      if (fin) best_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/max_search_ctrl.sv
// Sequencer: load image, run scan, collect window results.
// Clk/Reset plain; all job/datapath signals via bus (slave).
module max_search_ctrl
  import max_search_ctrl_pkg::*;
#(
  parameter int COL = 5,
  parameter int ROW = 4
) (
  input logic              Clk,
  input logic              Reset,
  max_search_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] LOAD  = 3'(ST_LOAD);
  localparam logic [2:0] SCAN  = 3'(ST_SCAN);
  localparam logic [2:0] DRAIN = 3'(ST_DRAIN);
  localparam logic [2:0] DONE  = 3'(ST_DONE);

  localparam logic [CNT_W-1:0] NPIX = npix(COL, ROW);
  localparam logic [CNT_W-1:0] NWIN = nwin(COL, ROW);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] res_cnt;

  logic is_idle, is_load, is_scan;
  logic is_drain, is_done;
  logic hs, acc, res_done, clr, fin;

  assign is_idle  = state == IDLE;
  assign is_load  = state == LOAD;
  assign is_scan  = state == SCAN;
  assign is_drain = state == DRAIN;
  assign is_done  = state == DONE;

  assign hs  = is_load && bus.PixValid;
  // results past NWIN are dropped
  assign acc = (is_scan || is_drain)
            && bus.WinValid
            && res_cnt != NWIN;
  // the NWIN-th result counts on the same edge
  assign res_done = res_cnt == NWIN
                 || (acc && res_cnt == NWIN - ONE);
  assign clr = is_idle && bus.Start;
  assign fin = is_drain && res_done;

  assign bus.PixReady = is_load;
  assign bus.ScanEn   = is_scan;
  assign bus.Busy     = is_load || is_scan || is_drain;
  assign bus.Done     = is_done;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      pix_cnt        <= '0;
      iss_cnt        <= '0;
      res_cnt        <= '0;
      bus.WE         <= 1'b0;
      bus.WA         <= '0;
      bus.D          <= '0;
      bus.PatternOut <= '0;
    end else begin
      bus.WE <= hs;
      if (hs) begin
        bus.WA  <= pix_cnt[ADDR_W-1:0];
        bus.D   <= bus.PixData;
        pix_cnt <= pix_cnt + ONE;
      end
      if (acc) res_cnt <= res_cnt + ONE;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            bus.PatternOut <= bus.Pattern;
            pix_cnt        <= '0;
            iss_cnt        <= '0;
            res_cnt        <= '0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (hs && pix_cnt == NPIX - ONE)
            state <= SCAN;
        end
        SCAN: begin
          iss_cnt <= iss_cnt + ONE;
          if (iss_cnt == NWIN - ONE)
            state <= DRAIN;
        end
        DRAIN: begin
          if (res_done) state <= DONE;
        end
        DONE: begin
          if (bus.Ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  max_tracker u_trk (
    .clk       (Clk),
    .rst       (Reset),
    .clr       (clr),
    .upd       (acc),
    .fin       (fin),
    .value     (bus.WinValue),
    .x         (bus.WinX),
    .y         (bus.WinY),
    .best_value(bus.BestValue),
    .best_x    (bus.BestX),
    .best_y    (bus.BestY),
    .best_valid(bus.BestValid)
  );

endmodule

// File: tb/tb_max_search_ctrl.sv
// Directed bench for max_search_ctrl, COL=5 ROW=4.
// Scoreboard queues for writes and final best result.
module tb_max_search_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  max_search_ctrl_if bus ();

  max_search_ctrl #(.COL(5), .ROW(4)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int we_cnt = 0;
  int scan_cnt = 0;
  int drain_cnt = 0;
  int dp_idx = 0;
  bit dp_on = 1'b0;
  int vals [6];
  int due [$];
  logic [17:0] ld_q [$];
  logic [20:0] exp_q [$];

  logic       hv;
  logic [7:0] bv;
  logic [6:0] bx;
  logic [5:0] by;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [17:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.WE === 1'b1) begin
      we_cnt++;
      if (ld_q.size() == 0) begin
        chk("we_extra", 32'd1, 32'd0);
      end else begin
        e = ld_q.pop_front();
        chk("wa", 32'(bus.WA), 32'(e[17:8]));
        chk("d", 32'(bus.D), 32'(e[7:0]));
      end
    end
    if (bus.ScanEn === 1'b1) begin
      scan_cnt++;
      if (dp_on) due.push_back(cyc + 3);
    end
    if (bus.Busy === 1'b1 && bus.ScanEn !== 1'b1
        && bus.PixReady !== 1'b1)
      drain_cnt++;
    bus.WinValid = 1'b0;
    if (due.size() > 0 && due[0] == cyc) begin
      void'(due.pop_front());
      bus.WinValid = 1'b1;
      bus.WinValue = 8'(vals[dp_idx]);
      bus.WinX     = 7'(2 + dp_idx % 3);
      bus.WinY     = 6'(2 + dp_idx / 3);
      if (!hv || bus.WinValue > bv) begin
        hv = 1'b1;
        bv = bus.WinValue;
        bx = bus.WinX;
        by = bus.WinY;
      end
      dp_idx++;
      if (dp_idx == 6) exp_q.push_back({bv, bx, by});
    end
  endtask

  task automatic start_job(input logic [1:0] p);
    dp_idx = 0;
    hv = 1'b0;
    bv = '0;
    bx = '0;
    by = '0;
    we_cnt = 0;
    scan_cnt = 0;
    drain_cnt = 0;
    bus.Start = 1'b1;
    bus.Pattern = p;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic load_job(input bit stall, input bit poke);
    int sent = 0;
    int guard = 0;
    bit tog = 1'b0;
    while (sent < 20 && guard < 100) begin
      guard++;
      tog = stall ? ~tog : 1'b1;
      if (poke && sent == 4) begin
        bus.Start = 1'b1;
        bus.Pattern = 2'd1;
      end else begin
        bus.Start = 1'b0;
      end
      if (tog && bus.PixReady === 1'b1) begin
        bus.PixValid = 1'b1;
        bus.PixData = 8'(10 + sent);
        ld_q.push_back({10'(sent), 8'(10 + sent)});
        sent++;
      end else begin
        bus.PixValid = 1'b0;
        bus.PixData = 8'hEE;
      end
      step();
    end
    bus.PixValid = 1'b0;
    bus.Start = 1'b0;
    if (sent < 20) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_to_done();
    int g = 0;
    while (bus.Done !== 1'b1 && g < 60) begin
      g++;
      step();
    end
    if (bus.Done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_best(input string tag);
    logic [20:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_value"}, 32'(bus.BestValue), 32'(e[20:13]));
      chk({tag, "_x"}, 32'(bus.BestX), 32'(e[12:6]));
      chk({tag, "_y"}, 32'(bus.BestY), 32'(e[5:0]));
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Pattern = 2'd0;
    bus.PixValid = 1'b0;
    bus.PixData = 8'd0;
    bus.WinValid = 1'b0;
    bus.WinValue = 8'd0;
    bus.WinX = 7'd0;
    bus.WinY = 6'd0;
    bus.Ack = 1'b0;
    hv = 1'b0;
    bv = '0;
    bx = '0;
    by = '0;

    // reset under random inputs
    for (int i = 0; i < 4; i++) begin
      bus.Start = 1'($urandom);
      bus.Pattern = 2'($urandom);
      bus.PixValid = 1'($urandom);
      bus.PixData = 8'($urandom);
      bus.Ack = 1'($urandom);
      step();
      bus.WinValid = 1'($urandom);
      bus.WinValue = 8'($urandom);
    end
    bus.Start = 1'b0;
    bus.PixValid = 1'b0;
    bus.Ack = 1'b0;
    step();
    chk("rst_pixready", 32'(bus.PixReady), 32'd0);
    chk("rst_we", 32'(bus.WE), 32'd0);
    chk("rst_wa", 32'(bus.WA), 32'd0);
    chk("rst_d", 32'(bus.D), 32'd0);
    chk("rst_scanen", 32'(bus.ScanEn), 32'd0);
    chk("rst_pattern", 32'(bus.PatternOut), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_bestv", 32'(bus.BestValue), 32'd0);
    chk("rst_bestx", 32'(bus.BestX), 32'd0);
    chk("rst_besty", 32'(bus.BestY), 32'd0);
    chk("rst_bvalid", 32'(bus.BestValid), 32'd0);
    rst = 1'b0;
    ld_q.delete();

    // job 1: stalled load, scan, tie handling
    vals = '{3, 9, 9, 4, 1, 7};
    dp_on = 1'b1;
    start_job(2'd2);
    chk("start_busy", 32'(bus.Busy), 32'd1);
    chk("start_pixready", 32'(bus.PixReady), 32'd1);
    chk("start_pattern", 32'(bus.PatternOut), 32'd2);
    load_job(1'b1, 1'b1);
    chk("load_we_count", 32'(we_cnt), 32'd20);
    chk("load_q_empty", 32'(ld_q.size()), 32'd0);
    chk("load_pixready_low", 32'(bus.PixReady), 32'd0);
    chk("load_scan_entered", 32'(bus.ScanEn), 32'd1);
    chk("load_start_ignored", 32'(bus.PatternOut), 32'd2);
    run_to_done();
    chk("scan_cycles", 32'(scan_cnt), 32'd6);
    chk("drain_cycles", 32'(drain_cnt), 32'd3);
    chk("done_busy", 32'(bus.Busy), 32'd0);
    chk("done_bvalid", 32'(bus.BestValid), 32'd1);
    check_best("job1");

    // Start in DONE is ignored
    bus.Start = 1'b1;
    bus.Pattern = 2'd3;
    step();
    bus.Start = 1'b0;
    chk("done_start_done", 32'(bus.Done), 32'd1);
    chk("done_start_pat", 32'(bus.PatternOut), 32'd2);
    chk("done_start_bv", 32'(bus.BestValue), 32'(bv));

    // Ack releases, Best* held
    bus.Ack = 1'b1;
    step();
    bus.Ack = 1'b0;
    chk("ack_done", 32'(bus.Done), 32'd0);
    chk("ack_busy", 32'(bus.Busy), 32'd0);
    chk("ack_bv_held", 32'(bus.BestValue), 32'(bv));
    chk("ack_bx_held", 32'(bus.BestX), 32'(bx));
    chk("ack_bvalid_held", 32'(bus.BestValid), 32'd1);

    // job 2: new Start clears, reset mid-scan
    vals = '{200, 201, 202, 203, 204, 205};
    start_job(2'd3);
    chk("new_bv_clear", 32'(bus.BestValue), 32'd0);
    chk("new_bvalid_clear", 32'(bus.BestValid), 32'd0);
    chk("new_pattern", 32'(bus.PatternOut), 32'd3);
    load_job(1'b0, 1'b0);
    begin
      int g = 0;
      while (scan_cnt < 3 && g < 20) begin
        g++;
        step();
      end
      if (scan_cnt < 3) chk("scan_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_scanen", 32'(bus.ScanEn), 32'd0);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("midrst_results_seen", 32'(dp_idx), 32'd3);
    chk("midrst_bv", 32'(bus.BestValue), 32'd0);
    chk("midrst_bvalid", 32'(bus.BestValid), 32'd0);
    chk("midrst_done", 32'(bus.Done), 32'd0);

    // job 3: full run, then Start+Ack together in DONE
    vals = '{5, 2, 8, 8, 0, 6};
    start_job(2'd0);
    load_job(1'b0, 1'b0);
    run_to_done();
    chk("job3_scan_cycles", 32'(scan_cnt), 32'd6);
    check_best("job3");
    bus.Start = 1'b1;
    bus.Pattern = 2'd1;
    bus.Ack = 1'b1;
    step();
    bus.Ack = 1'b0;
    chk("sa_done", 32'(bus.Done), 32'd0);
    chk("sa_busy_idle", 32'(bus.Busy), 32'd0);
    chk("sa_pattern", 32'(bus.PatternOut), 32'd0);
    step();
    bus.Start = 1'b0;
    chk("sa_restart_busy", 32'(bus.Busy), 32'd1);
    chk("sa_restart_pat", 32'(bus.PatternOut), 32'd1);
    chk("sa_restart_bvalid", 32'(bus.BestValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
